// File: rtl/transpose_pkg.sv
// Shared types and helpers for the streaming ping-pong transpose.
// Bank occupancy state, output FIFO depth and linear address math live here.
package transpose_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_state_e;

    localparam int FIFO_DEPTH = 2;

    function automatic logic [31:0] addr_of(
        input logic [31:0] row,
        input logic [31:0] col,
        input logic [31:0] cols
    );
        return (row * cols) + col;
    endfunction

endpackage

// File: rtl/transpose_bank_ram.sv
// Two-bank simple dual-port RAM: one write port, one synchronous read port.
// Bank 1 occupies the upper half of the array, above the ROWS*COLS entries of bank 0.
module transpose_bank_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 12,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk_p,
    input  logic                  wr_en,
    input  logic                  wr_bank,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  rd_bank,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int IDX_W = ADDR_W + 1;

    logic [DATA_WIDTH-1:0] mem_r [0:(2*DEPTH)-1];
    logic [IDX_W-1:0]      wr_idx_s;
    logic [IDX_W-1:0]      rd_idx_s;

    assign wr_idx_s = wr_bank ? (IDX_W'(DEPTH) + {1'b0, wr_addr}) : {1'b0, wr_addr};
    assign rd_idx_s = rd_bank ? (IDX_W'(DEPTH) + {1'b0, rd_addr}) : {1'b0, rd_addr};

    // Storage write port.
    always_ff @(posedge clk_p) begin
        if (wr_en) begin
            mem_r[wr_idx_s] <= wr_data;
        end
    end

    // Registered read port: data is valid the cycle after rd_en.
    always_ff @(posedge clk_p) begin
        if (rd_en) begin
            rd_data <= mem_r[rd_idx_s];
        end
    end

endmodule

// File: rtl/transpose_stream_pp.sv
// Streaming ROWS x COLS matrix transpose/bypass with ping-pong banks.
// Writer fills one bank row-major while the reader drains the other in the latched order.
module transpose_stream_pp
    import transpose_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 128,
    parameter int COLS       = 768
) (
    input  logic                  clk_p,
    input  logic                  rst_p,
    input  logic                  cfg_transpose,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [1:0]            bank_full
);

    localparam int DEPTH  = ROWS * COLS;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    bank_state_e           bank_st_r [2];
    logic                  mode_r    [2];
    logic                  ready_en_r;
    logic                  wr_bank_r;
    logic [ADDR_W-1:0]     wr_row_r;
    logic [ADDR_W-1:0]     wr_col_r;
    logic                  rd_bank_r;
    logic [ADDR_W-1:0]     rd_row_r;
    logic [ADDR_W-1:0]     rd_col_r;
    logic [ADDR_W-1:0]     rd_lin_r;
    logic                  pend_r;
    logic                  pend_last_r;
    logic [DATA_WIDTH-1:0] fifo_data_r [2];
    logic                  fifo_last_r [2];
    logic [1:0]            fifo_cnt_r;

    logic                  wr_fire_s;
    logic                  wr_first_s;
    logic                  wr_last_s;
    logic [ADDR_W-1:0]     wr_addr_s;
    logic                  rd_mode_s;
    logic                  rd_full_s;
    logic                  rd_room_s;
    logic                  rd_issue_s;
    logic                  rd_last_s;
    logic [ADDR_W-1:0]     rd_addr_s;
    logic [DATA_WIDTH-1:0] ram_rd_data_s;
    logic                  pop_s;
    logic                  direct_s;
    logic                  push_s;
    logic                  push_idx_s;
    logic [1:0]            fifo_cnt_n_s;
    logic [DATA_WIDTH-1:0] fifo_data_n_s [2];
    logic                  fifo_last_n_s [2];

    // Write side handshake and address; ready depends only on registered state.
    assign in_ready   = ready_en_r && (bank_st_r[wr_bank_r] == EMPTY);
    assign wr_fire_s  = in_valid && in_ready;
    assign wr_first_s = (wr_row_r == '0) && (wr_col_r == '0);
    assign wr_last_s  = (wr_row_r == ADDR_W'(ROWS - 1)) && (wr_col_r == ADDR_W'(COLS - 1));
    assign wr_addr_s  = ADDR_W'(addr_of(32'(wr_row_r), 32'(wr_col_r), 32'(COLS)));

    assign bank_full  = {(bank_st_r[1] == FULL), (bank_st_r[0] == FULL)};

    assign rd_mode_s  = mode_r[rd_bank_r];
    assign rd_full_s  = (bank_st_r[rd_bank_r] == FULL);
    // Counting in-flight reads keeps the 2-entry FIFO from ever overflowing.
    assign rd_room_s  = ({1'b0, fifo_cnt_r} + {2'b00, pend_r}) < 3'(FIFO_DEPTH);
    assign rd_issue_s = rd_full_s && rd_room_s;

    // Read address and end-of-matrix detection for the active order.
    always_comb begin
        rd_addr_s = '0;
        rd_last_s = 1'b0;
        if (rd_mode_s) begin
            rd_addr_s = ADDR_W'(addr_of(32'(rd_row_r), 32'(rd_col_r), 32'(COLS)));
            rd_last_s = (rd_row_r == ADDR_W'(ROWS - 1)) && (rd_col_r == ADDR_W'(COLS - 1));
        end else begin
            rd_addr_s = rd_lin_r;
            rd_last_s = (rd_lin_r == ADDR_W'(DEPTH - 1));
        end
    end

    transpose_bank_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk_p   (clk_p),
        .wr_en   (wr_fire_s),
        .wr_bank (wr_bank_r),
        .wr_addr (wr_addr_s),
        .wr_data (in_data),
        .rd_en   (rd_issue_s),
        .rd_bank (rd_bank_r),
        .rd_addr (rd_addr_s),
        .rd_data (ram_rd_data_s)
    );

    // Write counters, per-bank mode latch and bank occupancy flags.
    always_ff @(posedge clk_p) begin
        if (rst_p) begin
            ready_en_r   <= 1'b0;
            wr_bank_r    <= 1'b0;
            wr_row_r     <= '0;
            wr_col_r     <= '0;
            bank_st_r[0] <= EMPTY;
            bank_st_r[1] <= EMPTY;
            mode_r[0]    <= 1'b0;
            mode_r[1]    <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
            if (wr_fire_s) begin
                if (wr_first_s) begin
                    mode_r[wr_bank_r] <= cfg_transpose;
                end
                if (wr_last_s) begin
                    bank_st_r[wr_bank_r] <= FULL;
                    wr_bank_r            <= ~wr_bank_r;
                    wr_row_r             <= '0;
                    wr_col_r             <= '0;
                end else if (wr_col_r == ADDR_W'(COLS - 1)) begin
                    wr_col_r <= '0;
                    wr_row_r <= wr_row_r + ADDR_W'(1);
                end else begin
                    wr_col_r <= wr_col_r + ADDR_W'(1);
                end
            end
            // The writer never targets a full bank, so this never collides with the set above.
            if (rd_issue_s && rd_last_s) begin
                bank_st_r[rd_bank_r] <= EMPTY;
            end
        end
    end

    // Read counters and the in-flight flag tracking RAM output validity.
    always_ff @(posedge clk_p) begin
        if (rst_p) begin
            rd_bank_r   <= 1'b0;
            rd_row_r    <= '0;
            rd_col_r    <= '0;
            rd_lin_r    <= '0;
            pend_r      <= 1'b0;
            pend_last_r <= 1'b0;
        end else begin
            pend_r      <= rd_issue_s;
            pend_last_r <= rd_issue_s && rd_last_s;
            if (rd_issue_s) begin
                if (rd_last_s) begin
                    rd_bank_r <= ~rd_bank_r;
                    rd_row_r  <= '0;
                    rd_col_r  <= '0;
                    rd_lin_r  <= '0;
                end else if (rd_mode_s) begin
                    if (rd_row_r == ADDR_W'(ROWS - 1)) begin
                        rd_row_r <= '0;
                        rd_col_r <= rd_col_r + ADDR_W'(1);
                    end else begin
                        rd_row_r <= rd_row_r + ADDR_W'(1);
                    end
                end else begin
                    rd_lin_r <= rd_lin_r + ADDR_W'(1);
                end
            end
        end
    end

    // RAM data goes straight out when the FIFO is empty; otherwise it queues behind the head.
    assign pop_s      = out_ready && (fifo_cnt_r != 2'd0);
    assign direct_s   = out_ready && (fifo_cnt_r == 2'd0) && pend_r;
    assign push_s     = pend_r && !direct_s;
    assign push_idx_s = fifo_cnt_r[0] ^ pop_s;

    // FIFO next state: shift on pop, then place pushed data behind remaining entries.
    always_comb begin
        fifo_cnt_n_s     = fifo_cnt_r - {1'b0, pop_s} + {1'b0, push_s};
        fifo_data_n_s[0] = (push_s && !push_idx_s) ? ram_rd_data_s :
                           (pop_s ? fifo_data_r[1] : fifo_data_r[0]);
        fifo_last_n_s[0] = (push_s && !push_idx_s) ? pend_last_r :
                           (pop_s ? fifo_last_r[1] : fifo_last_r[0]);
        fifo_data_n_s[1] = (push_s && push_idx_s) ? ram_rd_data_s : fifo_data_r[1];
        fifo_last_n_s[1] = (push_s && push_idx_s) ? pend_last_r : fifo_last_r[1];
    end

    // FIFO occupancy register.
    always_ff @(posedge clk_p) begin
        if (rst_p) begin
            fifo_cnt_r <= 2'd0;
        end else begin
            fifo_cnt_r <= fifo_cnt_n_s;
        end
    end

    // FIFO payload registers; contents are qualified by occupancy.
    always_ff @(posedge clk_p) begin
        fifo_data_r[0] <= fifo_data_n_s[0];
        fifo_data_r[1] <= fifo_data_n_s[1];
        fifo_last_r[0] <= fifo_last_n_s[0];
        fifo_last_r[1] <= fifo_last_n_s[1];
    end

    // Output view: FIFO head when occupied, else the RAM read register.
    always_comb begin
        out_valid = (fifo_cnt_r != 2'd0) || pend_r;
        if (fifo_cnt_r != 2'd0) begin
            out_data = fifo_data_r[0];
            out_last = fifo_last_r[0];
        end else begin
            out_data = ram_rd_data_s;
            out_last = pend_r && pend_last_r;
        end
    end

endmodule

// File: tb/tb_transpose_stream_pp.sv
// Directed bench for transpose_stream_pp (3x4) with an output scoreboard queue.
module tb_transpose_stream_pp;

    localparam int R  = 3;
    localparam int C  = 4;
    localparam int N  = R * C;
    localparam int DW = 8;

    logic          clk_p;
    logic          rst_p;
    logic          cfg_transpose;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [1:0]    bank_full;

    int            chk_cnt;
    int            pass_cnt;
    int            fail_cnt;
    logic [8:0]    exp_q [$];
    logic          hold_v;
    logic [8:0]    hold_val;
    logic          rnd_en;
    logic          hs_r;

    transpose_stream_pp #(
        .DATA_WIDTH (DW),
        .ROWS       (R),
        .COLS       (C)
    ) dut (
        .clk_p         (clk_p),
        .rst_p         (rst_p),
        .cfg_transpose (cfg_transpose),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .bank_full     (bank_full)
    );

    always #5 clk_p = ~clk_p;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample/score at the falling edge, return 1 time unit after the rising edge.
    task automatic step();
        logic [8:0] e;
        @(negedge clk_p);
        hs_r = in_valid && in_ready;
        if (hold_v) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'({out_last, out_data}), 32'(hold_val));
        end
        hold_v = 1'b0;
        if (out_valid === 1'b1) begin
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_elem", 32'({out_last, out_data}), 32'(e));
                end
            end else begin
                hold_v   = 1'b1;
                hold_val = {out_last, out_data};
            end
        end
        @(posedge clk_p);
        #1;
        if (rnd_en) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_elems(input int base, input int n, input logic mode, output int stalls);
        int w;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            in_valid      = 1'b1;
            in_data       = DW'(base + i);
            cfg_transpose = mode;
            w = 1;
            step();
            while (!hs_r && w < 100) begin
                step();
                w++;
            end
            if (!hs_r) check("in_accept_timeout", 32'(hs_r), 32'd1);
            stalls += w - 1;
        end
        in_valid = 1'b0;
    endtask

    task automatic push_expected(input int base, input logic mode);
        int r;
        int c;
        for (int k = 0; k < N; k++) begin
            if (mode) begin
                c = k / R;
                r = k % R;
            end else begin
                r = k / C;
                c = k % C;
            end
            exp_q.push_back({(k == N - 1), DW'(base + r * C + c)});
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 300) begin
            step();
            w++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int st;
        int acc;
        int w;
        clk_p = 1'b0; rst_p = 1'b1; cfg_transpose = 1'b0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b1; rnd_en = 1'b0; hold_v = 1'b0; hs_r = 1'b0;
        chk_cnt = 0; pass_cnt = 0; fail_cnt = 0;

        // Reset state
        step(); step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_bank_full", 32'(bank_full), 32'd0);
        rst_p = 1'b0;
        step();
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Transpose with latency check
        send_elems(0, N, 1'b1, st);
        push_expected(0, 1'b1);
        check("t1_bank_full", 32'(bank_full), 32'd1);
        check("lat_edge_k", 32'(out_valid), 32'd0);
        step();
        check("lat_edge_k1", 32'(out_valid), 32'd1);
        drain();

        // Bypass
        send_elems(0, N, 1'b0, st);
        push_expected(0, 1'b0);
        drain();

        // Back-to-back with mode flip
        acc = 0;
        send_elems(0, N, 1'b1, st);
        acc += st;
        push_expected(0, 1'b1);
        send_elems(100, N, 1'b0, st);
        acc += st;
        push_expected(100, 1'b0);
        check("b2b_stalls", 32'(acc), 32'd0);
        drain();

        // Both banks full under sustained backpressure
        out_ready = 1'b0;
        send_elems(0, N, 1'b1, st);
        push_expected(0, 1'b1);
        send_elems(12, N, 1'b0, st);
        push_expected(12, 1'b0);
        check("both_full", 32'(bank_full), 32'd3);
        in_valid = 1'b1;
        in_data  = 8'd200;
        step();
        check("full_no_hs", 32'(hs_r), 32'd0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("release_in_ready", 32'(in_ready), 32'd0);
        w = 0;
        while (!in_ready && w < 40) begin
            step();
            w++;
        end
        check("ready_return", 32'(in_ready), 32'd1);
        check("after_free_bank", 32'(bank_full), 32'd2);
        drain();

        // Random backpressure over four matrices
        rnd_en = 1'b1;
        for (int m = 0; m < 4; m++) begin
            send_elems(128 + 16 * m, N, 1'(m % 2 == 0), st);
            push_expected(128 + 16 * m, 1'(m % 2 == 0));
        end
        drain();
        rnd_en    = 1'b0;
        out_ready = 1'b1;
        step();

        // Reset mid-matrix discards the partial one
        send_elems(50, 7, 1'b1, st);
        rst_p = 1'b1;
        step();
        check("midrst_out_valid0", 32'(out_valid), 32'd0);
        step();
        check("midrst_out_valid1", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        rst_p = 1'b0;
        step();
        check("midrst_bank_full", 32'(bank_full), 32'd0);
        send_elems(20, N, 1'b1, st);
        push_expected(20, 1'b1);
        drain();
        repeat (3) step();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
